// File: rtl/cac_fns_pkg.sv
// Shared definitions for the sequential FNS crosstalk-avoidance encoder:
// FSM states, packed-entry slicing helper and the default 9-wire Fibonacci tables.
package cac_fns_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ENC  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Upper bounds the slicing helper can address; weights wider than this are not supported.
    localparam int PICK_W    = 1024;
    localparam int PICK_LOG  = 10;
    localparam int FNS_MAX_W = 32;

    // Default tables for 9 wires, 8-bit entries, wire 8 in the top byte.
    localparam logic [71:0] FNS_SUB_DEFAULT =
        {8'd34, 8'd21, 8'd13, 8'd8, 8'd5, 8'd3, 8'd2, 8'd1, 8'd1};
    localparam logic [71:0] FNS_CMP_DEFAULT =
        {8'd34, 8'd34, 8'd13, 8'd13, 8'd5, 8'd5, 8'd2, 8'd2, 8'd1};

    // Returns packed entry i of the given width, zero-extended to FNS_MAX_W bits.
    function automatic logic [FNS_MAX_W-1:0] fns_pick(
        input logic [PICK_W-1:0] w,
        input int unsigned       i,
        input int unsigned       width
    );
        logic [FNS_MAX_W-1:0] m;
        int unsigned          k;
        m = '0;
        for (int unsigned b = 0; b < FNS_MAX_W; b++) begin
            k = i * width + b;
            if (b < width && k < PICK_W) begin
                m[b] = w[k[PICK_LOG-1:0]];
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/cac_fns_step.sv
// One greedy FNS decomposition step for a single wire: decide the wire bit
// and produce the updated residual, clamping to zero if the weight exceeds it.
module cac_fns_step #(
    parameter int RW = 9,
    parameter int CW = 32
) (
    input  logic [RW-1:0] r,
    input  logic          en,
    input  logic [CW-1:0] cmp,
    input  logic [CW-1:0] sub,
    output logic          code_bit,
    output logic [RW-1:0] r_next,
    output logic          underflow
);

    localparam int XW = RW + CW;

    always_comb begin
        // NOTE: every output gets a default before any branch so no latch is inferred.
        r_next    = r;
        code_bit  = en && (XW'(r) >= XW'(cmp));
        underflow = code_bit && (XW'(r) < XW'(sub));
        if (underflow) begin
            r_next = '0;
        end else if (code_bit) begin
            r_next = r - RW'(sub);
        end
    end

endmodule

// File: rtl/cac_fns_seq_encoder.sv
// Multi-cycle FNS crosstalk-avoidance encoder: one wire per cycle, MSB first,
// with valid/ready handshakes toward the data source and the TSV driver.
module cac_fns_seq_encoder
    import cac_fns_pkg::*;
#(
    parameter int N_WIRES = 9,
    parameter int DATA_W  = 8,
    parameter int FNS_W   = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        datain,
    input  logic [N_WIRES-1:0]       en_flag,
    input  logic [N_WIRES*FNS_W-1:0] fns_sub,
    input  logic [N_WIRES*FNS_W-1:0] fns_cmp,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N_WIRES-1:0]       codeout,
    output logic                     err
);

    localparam int RW = ((DATA_W > FNS_W) ? DATA_W : FNS_W) + 1;
    localparam int IW = $clog2(N_WIRES);
    localparam int NF = N_WIRES * FNS_W;

    state_e               state;
    logic [RW-1:0]        r;
    logic [IW-1:0]        idx;
    logic [N_WIRES-1:0]   code;
    logic [N_WIRES-1:0]   en_q;
    logic [NF-1:0]        sub_q;
    logic [NF-1:0]        cmp_q;
    logic                 uf_q;

    logic [FNS_MAX_W-1:0] sub_cur;
    logic [FNS_MAX_W-1:0] cmp_cur;
    logic                 step_bit;
    logic                 step_uf;
    logic [RW-1:0]        r_next;

    always_comb begin
        sub_cur = fns_pick(PICK_W'(sub_q), 32'(idx), FNS_W);
        cmp_cur = fns_pick(PICK_W'(cmp_q), 32'(idx), FNS_W);
    end

    cac_fns_step #(
        .RW (RW),
        .CW (FNS_MAX_W)
    ) u_step (
        .r         (r),
        .en        (en_q[idx]),
        .cmp       (cmp_cur),
        .sub       (sub_cur),
        .code_bit  (step_bit),
        .r_next    (r_next),
        .underflow (step_uf)
    );

    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (reset) begin
            state <= IDLE;
            r     <= '0;
            idx   <= '0;
            code  <= '0;
            en_q  <= '0;
            sub_q <= '0;
            cmp_q <= '0;
            uf_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        r     <= RW'(datain);
                        en_q  <= en_flag;
                        sub_q <= fns_sub;
                        cmp_q <= fns_cmp;
                        idx   <= IW'(N_WIRES - 1);
                        code  <= '0;
                        uf_q  <= 1'b0;
                        state <= ENC;
                    end
                end
                ENC: begin
                    code[idx] <= step_bit;
                    r         <= r_next;
                    uf_q      <= uf_q | step_uf;
                    if (idx == '0) begin
                        state <= DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are gated by out_valid so nothing stale leaks while idle or encoding.
    assign in_ready  = (state == IDLE) && !reset;
    assign out_valid = (state == DONE);
    assign codeout   = out_valid ? (code & en_q) : '0;
    assign err       = out_valid && ((r != '0) || uf_q);

endmodule

// File: tb/tb_cac_fns_seq_encoder.sv
// Self-checking bench for cac_fns_seq_encoder: directed boundary words plus
// randomized words checked against an arithmetic greedy-decomposition model.
module tb_cac_fns_seq_encoder;
    import cac_fns_pkg::*;

    localparam int N  = 9;
    localparam int DW = 8;
    localparam int FW = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] datain;
    logic [N-1:0]  en_flag;
    logic [N*FW-1:0] fns_sub;
    logic [N*FW-1:0] fns_cmp;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  codeout;
    logic          err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    cac_fns_seq_encoder #(
        .N_WIRES (N),
        .DATA_W  (DW),
        .FNS_W   (FW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .datain    (datain),
        .en_flag   (en_flag),
        .fns_sub   (fns_sub),
        .fns_cmp   (fns_cmp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .codeout   (codeout),
        .err       (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Greedy decomposition straight from the rules: walk wires high to low on an integer residual.
    function automatic void model(
        input  logic [DW-1:0]   d,
        input  logic [N-1:0]    en,
        input  logic [N*FW-1:0] sub,
        input  logic [N*FW-1:0] cmp,
        output logic [N-1:0]    code,
        output logic            e
    );
        int rr;
        int s;
        int c;
        bit uf;
        rr   = int'(d);
        uf   = 0;
        code = '0;
        for (int i = N - 1; i >= 0; i--) begin
            s = int'(sub[i*FW +: FW]);
            c = int'(cmp[i*FW +: FW]);
            if (en[i] && rr >= c) begin
                code[i] = 1'b1;
                if (rr < s) begin
                    rr = 0;
                    uf = 1;
                end else begin
                    rr = rr - s;
                end
            end
        end
        e = (rr != 0) || uf;
    endfunction

    // Entered and left at posedge+1. hold==0 keeps out_ready high the whole time.
    task automatic run_word(
        input string           tag,
        input logic [DW-1:0]   d,
        input logic [N-1:0]    en,
        input logic [N*FW-1:0] sub,
        input logic [N*FW-1:0] cmp,
        input int              hold,
        input logic [N-1:0]    exp_code,
        input logic            exp_err
    );
        int lat;
        check({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        datain    = d;
        en_flag   = en;
        fns_sub   = sub;
        fns_cmp   = cmp;
        out_ready = (hold == 0);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        datain   = DW'($urandom);
        en_flag  = N'($urandom);
        for (int b = 0; b < N; b++) begin
            fns_sub[b*FW +: FW] = FW'($urandom);
            fns_cmp[b*FW +: FW] = FW'($urandom);
        end
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clock);
            #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(N + 1));
        check({tag, " codeout"}, 32'(codeout), 32'(exp_code));
        check({tag, " err"}, 32'(err), 32'(exp_err));
        if (hold > 0) begin
            for (int k = 0; k < hold; k++) begin
                in_valid = (k == 1);
                datain   = DW'($urandom);
                check({tag, " held out_valid"}, 32'(out_valid), 32'd1);
                check({tag, " held codeout"}, 32'(codeout), 32'(exp_code));
                check({tag, " held err"}, 32'(err), 32'(exp_err));
                check({tag, " held in_ready"}, 32'(in_ready), 32'd0);
                @(posedge clock);
                #1;
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        check({tag, " out_valid drops"}, 32'(out_valid), 32'd0);
        check({tag, " back to idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [N-1:0]    mc;
        logic            me;
        logic [DW-1:0]   d;
        logic [N-1:0]    en;
        logic [N*FW-1:0] sub;
        logic [N*FW-1:0] cmp;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        datain    = '0;
        en_flag   = '0;
        fns_sub   = '0;
        fns_cmp   = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset in_ready", 32'(in_ready), 32'd0);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset codeout", 32'(codeout), 32'd0);
        check("reset err", 32'(err), 32'd0);
        reset = 1'b0;
        #1;
        check("post-reset in_ready", 32'(in_ready), 32'd1);

        run_word("d0",      8'd0,   9'h1FF, FNS_SUB_DEFAULT, FNS_CMP_DEFAULT, 2, 9'h000, 1'b0);
        run_word("d55",     8'd55,  9'h1FF, FNS_SUB_DEFAULT, FNS_CMP_DEFAULT, 1, 9'h155, 1'b0);
        run_word("d34_w8",  8'd34,  9'h0FF, FNS_SUB_DEFAULT, FNS_CMP_DEFAULT, 1, 9'h0C0, 1'b0);
        run_word("d100",    8'd100, 9'h1FF, FNS_SUB_DEFAULT, FNS_CMP_DEFAULT, 1, 9'h1FF, 1'b1);
        run_word("hold5",   8'd34,  9'h1FF, FNS_SUB_DEFAULT, FNS_CMP_DEFAULT, 5, 9'h100, 1'b0);
        run_word("en0",     8'd77,  9'h000, FNS_SUB_DEFAULT, FNS_CMP_DEFAULT, 1, 9'h000, 1'b1);
        run_word("zero_w",  8'd3,   9'h003, '0,              '0,              1, 9'h003, 1'b1);
        run_word("clamp",   8'd5,   9'h100, {8'd9, 64'd0},   {8'd4, 64'd0},   1, 9'h100, 1'b1);
        run_word("b2b_a",   8'd55,  9'h1FF, FNS_SUB_DEFAULT, FNS_CMP_DEFAULT, 0, 9'h155, 1'b0);
        run_word("b2b_b",   8'd1,   9'h1FF, FNS_SUB_DEFAULT, FNS_CMP_DEFAULT, 0, 9'h001, 1'b0);

        // Abort a word mid-encode: after the accept edge idx is 8, four more edges bring it to 4.
        in_valid = 1'b1;
        datain   = 8'd55;
        en_flag  = 9'h1FF;
        fns_sub  = FNS_SUB_DEFAULT;
        fns_cmp  = FNS_CMP_DEFAULT;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("abort out_valid", 32'(out_valid), 32'd0);
        check("abort codeout", 32'(codeout), 32'd0);
        check("abort in_ready", 32'(in_ready), 32'd0);
        reset = 1'b0;
        #1;
        check("abort in_ready after reset", 32'(in_ready), 32'd1);
        run_word("after_abort", 8'd34, 9'h1FF, FNS_SUB_DEFAULT, FNS_CMP_DEFAULT, 1, 9'h100, 1'b0);

        for (int t = 0; t < 20; t++) begin
            d  = DW'($urandom);
            en = ($urandom_range(0, 1) == 0) ? 9'h1FF : N'($urandom);
            model(d, en, FNS_SUB_DEFAULT, FNS_CMP_DEFAULT, mc, me);
            run_word("rand_def", d, en, FNS_SUB_DEFAULT, FNS_CMP_DEFAULT,
                     $urandom_range(0, 2), mc, me);
        end

        for (int t = 0; t < 15; t++) begin
            d  = DW'($urandom);
            en = N'($urandom);
            for (int b = 0; b < N; b++) begin
                sub[b*FW +: FW] = FW'($urandom_range(0, 40));
                cmp[b*FW +: FW] = FW'($urandom_range(0, 60));
            end
            model(d, en, sub, cmp, mc, me);
            run_word("rand_wt", d, en, sub, cmp, $urandom_range(0, 2), mc, me);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cac_fns_seq_encoder.md
Name: cac_fns_seq_encoder

Overview:
- Parametrised, multi-cycle successor to the fixed 9-wire FNS CAC encoder.
- Converts a binary data word into an N_WIRES-bit crosstalk-avoidance codeword by greedy Fibonacci-numeral-system decomposition, one wire per cycle, MSB first.
- Skips wires that are masked off by the per-wire enable flag, which marks faulty or redundant TSVs.
- Sits between the link data source and the TSV bundle driver, with valid/ready handshakes on both sides.

Parameters:
- N_WIRES, 9, number of TSV wires (codeword width), must be at least 2.
- DATA_W, 8, input data width.
- FNS_W, 8, width of each weight and threshold entry.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  datain and config are valid.
- in_ready  out  1  block can accept a word.
- datain  in  DATA_W  binary word to encode.
- en_flag  in  N_WIRES  per-wire enable; 0 means the wire is forced low.
- fns_sub  in  N_WIRES*FNS_W  per-wire subtract weight; entry i is at bits [i*FNS_W +: FNS_W].
- fns_cmp  in  N_WIRES*FNS_W  per-wire compare threshold, same packing.
- out_valid  out  1  codeout is valid.
- out_ready  in  1  downstream accepts codeout.
- codeout  out  N_WIRES  encoded word.
- err  out  1  residual was nonzero after bit 0, i.e. datain is not representable.

Behaviour:
- Reset:
  - in_ready=0 during reset; in_ready=1 in the first cycle after reset deasserts.
  - out_valid=0, codeout=0, err=0, state=IDLE.
  - Reset applied mid-encode aborts the word; no output is produced for it.
- States: IDLE, ENC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, capture datain into residual r (zero-extended to max(DATA_W,FNS_W)+1 bits).
  - Also capture en_flag, fns_sub and fns_cmp. The config is held stable for the whole word; input changes after accept have no effect.
  - Set idx=N_WIRES-1, clear the code register, go to ENC.
- ENC:
  - One wire per cycle.
  - bit[idx] = en[idx] && (r >= cmp[idx]).
  - If bit[idx]=1 then r <= r - sub[idx]; otherwise r is unchanged.
  - A disabled wire yields bit 0, r unchanged, and still consumes one cycle. Cycle count is fixed.
  - When idx==0, go to DONE after this cycle's update.
- DONE:
  - out_valid=1, codeout = code register (always ANDed with captured en).
  - err = (final r != 0).
  - Outputs are held stable while out_valid && !out_ready.
  - On out_ready, go to IDLE; out_valid drops next cycle.
- Latency: accept edge at cycle t gives out_valid=1 at cycle t+N_WIRES+1.
- Throughput: one word per N_WIRES+2 cycles, since the block is not pipelined. in_ready=0 in ENC and DONE.
- Arithmetic:
  - Unsigned throughout; compare and subtract on the extended residual width.
  - Subtraction only occurs when r >= cmp. Because cmp >= sub is required of the weight generator, r never underflows.
  - If the generator violates cmp >= sub and r < sub, r clamps to 0 and err is set.
- Boundaries:
  - datain=0 gives codeout=0, err=0.
  - en_flag all zero gives codeout=0, err = (datain != 0).
  - A weight or threshold entry of 0 with en=1 forces bit=1 and subtracts sub (cmp=0 always passes).
  - out_ready held high in DONE: exactly one output cycle, then IDLE. A new word can be accepted in the IDLE cycle that follows.

Decomposition:
- Shared package cac_fns_pkg:
  - state enum {IDLE, ENC, DONE}.
  - Function fns_pick(w, i) that slices packed entry i.
  - Default 9-wire Fibonacci constants:
    - sub = {34,21,13,8,5,3,2,1,1}, listed bit8 down to bit0.
    - cmp = {34,34,13,13,5,5,2,2,1}, listed bit8 down to bit0.
- Sub-module cac_fns_step: combinational single-wire stage with inputs r, en, cmp, sub and outputs bit, r_next, underflow. It is instantiated once and reused every cycle.

Test Plan:
- Default constants, en=0x1FF, datain=0 -> codeout=0x000, err=0, out_valid exactly 10 cycles after accept.
- Default constants, en=0x1FF, datain=55 -> codeout=0x155, err=0.
- Default constants, en=0x0FF (wire 8 disabled), datain=34 -> codeout=0x0C0, err=0.
- Default constants, en=0x1FF, datain=100 -> codeout=0x1FF, err=1 (residual 12).
- out_ready held low for 5 cycles in DONE with datain=34, en=0x1FF -> codeout=0x100 stable for all 5 cycles, in_ready=0; a second in_valid pulse is ignored until IDLE.
- reset asserted at idx=4 during datain=55 -> next cycle out_valid=0, codeout=0; first cycle after reset deasserts in_ready=1; then datain=34 -> codeout=0x100.
